// File: rtl/ama_riscv_rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Register-address width, data width and x0 handling live here.
package ama_riscv_rf_wb_arbiter_pkg;

  localparam int  RF_ADDR_W  = 5;
  localparam int  XLEN       = 32;
  localparam int  RF_NREGS   = 1 << RF_ADDR_W;
  localparam bit  RF_X0_ZERO = 1'b1;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  function automatic logic is_x0(
    input logic [RF_ADDR_W-1:0] a
  );
    return RF_X0_ZERO && (a == '0);
  endfunction

endpackage

// File: rtl/ama_riscv_wb_fifo.sv
// Long-latency writeback buffer: rd+data entries, push/pop in any cycle.
// Ports: push/push_rd/push_data in, pop in, head_rd/head_data/full/empty/count out.
module ama_riscv_wb_fifo
  import ama_riscv_rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [RF_ADDR_W-1:0] push_rd,
  input  logic [XLEN-1:0]      push_data,
  input  logic                 pop,
  output logic [RF_ADDR_W-1:0] head_rd,
  output logic [XLEN-1:0]      head_data,
  output logic                 full,
  output logic                 empty,
  output logic [PW:0]          count
);

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full      = (cnt_q == (PW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign head_rd   = mem_q[rptr_q].rd;
  assign head_data = mem_q[rptr_q].data;

  // A push at full is legal only when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = '{rd: push_rd, data: push_data};
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ama_riscv_rf_wb_arbiter.sv
// Arbitrates the RF write port between EX and buffered long-latency results.
// Ports: ex_*, lsu_*/lsu_ready, iss_*, rs1/rs2_addr in; stall, ex_hold, rf_* out.
module ama_riscv_rf_wb_arbiter
  import ama_riscv_rf_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_we,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        stall,
  output logic        ex_hold,
  output logic        rf_we,
  output logic [4:0]  rf_addr_d,
  output logic [31:0] rf_data_d
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic                 ex_req, push, pop;
  logic                 full, empty, busy;
  logic [PW:0]          fifo_cnt;
  logic [RF_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]      head_data;

  logic [RF_NREGS-1:0]  pend_q, pend_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic                 ex_hold_q, ex_hold_d;

  ama_riscv_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_cnt)
  );

  // The hold cycle masks EX so the buffer head gets the port.
  assign ex_req    = ex_we & ~is_x0(ex_rd) & ~ex_hold_q;
  assign pop       = ~empty & ~ex_req;
  assign lsu_ready = ~full | pop;
  assign push      = lsu_valid & lsu_ready & ~is_x0(lsu_rd);
  assign busy      = (fifo_cnt != '0);
  assign ex_hold   = ex_hold_q;

  always_comb begin
    rf_we     = 1'b0;
    rf_addr_d = '0;
    rf_data_d = '0;
    unique case (1'b1)
      ex_req: begin
        rf_we     = 1'b1;
        rf_addr_d = ex_rd;
        rf_data_d = ex_data;
      end
      pop: begin
        rf_we     = 1'b1;
        rf_addr_d = head_rd;
        rf_data_d = head_data;
      end
      default: ;
    endcase
  end

  // Clear on drain first so a same-cycle reissue keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (pop) begin
      pend_d[head_rd] = 1'b0;
    end
    if (iss_valid && !is_x0(iss_rd)) begin
      pend_d[iss_rd] = 1'b1;
    end
  end

  always_comb begin
    stall = 1'b0;
    if (!is_x0(rs1_addr) && pend_q[rs1_addr]) stall = 1'b1;
    if (!is_x0(rs2_addr) && pend_q[rs2_addr]) stall = 1'b1;
    if (iss_valid && !is_x0(iss_rd) && pend_q[iss_rd]) stall = 1'b1;
  end

  always_comb begin
    cnt_d     = cnt_q;
    ex_hold_d = 1'b0;
    if (!busy || pop) begin
      cnt_d = '0;
    end else if (ex_req) begin
      if (cnt_q == SW'(STARVE_LIM - 1)) begin
        ex_hold_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      cnt_q     <= '0;
      ex_hold_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      ex_hold_q <= ex_hold_d;
    end
  end

endmodule

// File: tb/tb_ama_riscv_rf_wb_arbiter.sv
// Directed bench for the RF writeback arbiter.
// Inputs change 1ns after the rising edge; outputs sampled 2ns later.
module tb_ama_riscv_rf_wb_arbiter;

  logic        clk, rst_n;
  logic        ex_we;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        stall, ex_hold;
  logic        rf_we;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_data_d;

  int n_vec;
  int n_bad;

  ama_riscv_rf_wb_arbiter #(
    .FIFO_DEPTH (2),
    .STARVE_LIM (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_we     (ex_we),
    .ex_rd     (ex_rd),
    .ex_data   (ex_data),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .stall     (stall),
    .ex_hold   (ex_hold),
    .rf_we     (rf_we),
    .rf_addr_d (rf_addr_d),
    .rf_data_d (rf_data_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic we,
                        input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(rf_we), 32'(we));
    chk({tag, "_addr"}, 32'(rf_addr_d), 32'(a));
    chk({tag, "_data"}, rf_data_d, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    ex_we = 0; ex_rd = 0; ex_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    iss_valid = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(lsu_ready), 1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_hold", 32'(ex_hold), 0);
    chk_rf("rst_rf", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // EX only, same-cycle write
    ex_we = 1; ex_rd = 5; ex_data = 32'hDEADBEEF;
    settle();
    chk_rf("ex_only", 1, 5, 32'hDEADBEEF);
    ex_rd = 0;
    settle();
    chk_rf("ex_x0", 0, 0, 0);
    tick();

    // scoreboard on rd=7
    ex_we = 0;
    iss_valid = 1; iss_rd = 7;
    settle();
    chk("iss7_nostall", 32'(stall), 0);
    tick();
    iss_valid = 0; rs1_addr = 7;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    settle();
    chk("sb_stall", 32'(stall), 1);
    chk("sb_ready", 32'(lsu_ready), 1);
    chk_rf("sb_enq", 0, 0, 0);
    tick();
    lsu_valid = 0;
    settle();
    chk_rf("sb_wr", 1, 7, 32'h1234);
    chk("sb_stall_wr", 32'(stall), 1);
    tick();
    settle();
    chk("sb_stall_drop", 32'(stall), 0);
    chk_rf("sb_idle", 0, 0, 0);
    rs1_addr = 0;
    tick();

    // full buffer, EX busy every cycle
    ex_we = 1; ex_rd = 3; ex_data = 32'h11;
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hA0;
    settle();
    chk("full_rdy0", 32'(lsu_ready), 1);
    chk_rf("full_ex0", 1, 3, 32'h11);
    tick();
    ex_data = 32'h12;
    lsu_rd = 11; lsu_data = 32'hA1;
    settle();
    chk("full_rdy1", 32'(lsu_ready), 1);
    tick();
    ex_data = 32'h13;
    lsu_rd = 12; lsu_data = 32'hA2;
    settle();
    chk("full_rdy2", 32'(lsu_ready), 0);
    chk_rf("full_ex2", 1, 3, 32'h13);
    tick();
    // EX idle at full: pop + push together
    ex_we = 0;
    settle();
    chk("full_pp_rdy", 32'(lsu_ready), 1);
    chk_rf("full_pp_wr", 1, 10, 32'hA0);
    tick();
    lsu_valid = 0;
    ex_we = 1; ex_data = 32'h14;
    settle();
    chk("full_still", 32'(lsu_ready), 0);
    tick();
    ex_we = 0;
    settle();
    chk_rf("drain1", 1, 11, 32'hA1);
    tick();
    settle();
    chk_rf("drain2", 1, 12, 32'hA2);
    tick();
    settle();
    chk_rf("drained", 0, 0, 0);
    chk("drained_rdy", 32'(lsu_ready), 1);

    // LSU beat to x0 is accepted but dropped
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFF;
    settle();
    chk("x0_rdy", 32'(lsu_ready), 1);
    tick();
    lsu_valid = 0;
    settle();
    chk_rf("x0_drop", 0, 0, 0);
    tick();

    // starvation: one entry, EX busy 4 cycles, then hold
    ex_we = 1; ex_rd = 3; ex_data = 32'h21;
    lsu_valid = 1; lsu_rd = 13; lsu_data = 32'h55;
    tick();
    lsu_valid = 0;
    ex_rd = 4; ex_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("st_nohold", 32'(ex_hold), 0);
      chk_rf("st_ex", 1, 4, 32'hB0);
      tick();
    end
    settle();
    chk("st_hold", 32'(ex_hold), 1);
    chk_rf("st_head", 1, 13, 32'h55);
    tick();
    ex_we = 0;
    settle();
    chk("st_hold_off", 32'(ex_hold), 0);
    chk_rf("st_after", 0, 0, 0);

    // same-cycle issue and drain of rd=9
    iss_valid = 1; iss_rd = 9;
    tick();
    iss_valid = 0;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    tick();
    lsu_valid = 0;
    iss_valid = 1; iss_rd = 9;
    settle();
    chk_rf("sd_drain", 1, 9, 32'h99);
    chk("sd_iss_stall", 32'(stall), 1);
    tick();
    iss_valid = 0; rs2_addr = 9;
    settle();
    chk("sd_rs2_stall", 32'(stall), 1);
    tick();
    rs2_addr = 0;

    // reset mid-operation
    iss_valid = 1; iss_rd = 20;
    tick();
    iss_rd = 21;
    tick();
    iss_rd = 22;
    ex_we = 1; ex_rd = 2; ex_data = 32'h31;
    lsu_valid = 1; lsu_rd = 20; lsu_data = 32'hC0;
    tick();
    iss_valid = 0;
    lsu_rd = 21; lsu_data = 32'hC1;
    tick();
    lsu_valid = 0;
    rs1_addr = 20; rs2_addr = 22;
    settle();
    chk("pre_rst_ready", 32'(lsu_ready), 0);
    chk("pre_rst_stall", 32'(stall), 1);
    ex_we = 0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(lsu_ready), 1);
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_hold", 32'(ex_hold), 0);
    chk_rf("mid_rst_rf", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    settle();
    chk_rf("post_rst_rf", 0, 0, 0);
    chk("post_rst_ready", 32'(lsu_ready), 1);
    chk("post_rst_stall", 32'(stall), 0);
    chk("post_rst_hold", 32'(ex_hold), 0);
    ex_we = 1; ex_rd = 6; ex_data = 32'h66;
    settle();
    chk_rf("post_rst_ex", 1, 6, 32'h66);
    tick();
    ex_we = 0;
    settle();
    chk_rf("post_rst_idle", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
